// File: rtl/pl_run_controller.sv
// pl_run_controller
//   Bounded run supervisor for an array of pipelined cores. It sequences a
//   parametrised core reset and tracks per-core halts and per-core cycle
//   counts. A watchdog ends the run after MAX_CYCLES RUN cycles if the cores
//   have not all halted by then.
//
//   state | meaning
//   IDLE  | after controller reset; cores held in reset, waiting for start
//   RESET | core_rst held high for RESET_CYCLES edges
//   RUN   | cores running; counting cycles, collecting halts, watchdog armed
//   DONE  | run finished (all halted or timeout); results held until start
//
// Ports
//   clk_i              single clock, rising edge
//   rst_i              synchronous active-high controller reset
//   start_i            run request, sampled in IDLE and DONE only
//   core_en_i          per-core enable, sampled on the RESET->RUN transition
//   hlt_i              per-core halt strobe (hlt instruction retired)
//   core_rst_o         registered reset to all cores
//   state_o            0 IDLE, 1 RESET, 2 RUN, 3 DONE
//   halted_mask_o      core i has halted or is disabled
//   cycles_consumed_o  per-core cycle count, core i at [i*CNT_W +: CNT_W]
//   global_cycles_o    RUN cycles elapsed in the current run
//   done_o             run finished (halt or timeout), sticky
//   timeout_o          run ended by the watchdog, sticky
module pl_run_controller #(
  parameter int N_CORES      = 1,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 200000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [N_CORES-1:0]         core_en_i,
  input  logic [N_CORES-1:0]         hlt_i,
  output logic                       core_rst_o,
  output logic [1:0]                 state_o,
  output logic [N_CORES-1:0]         halted_mask_o,
  output logic [N_CORES*CNT_W-1:0]   cycles_consumed_o,
  output logic [CNT_W-1:0]           global_cycles_o,
  output logic                       done_o,
  output logic                       timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Pre-increment value of global_cycles on the MAX_CYCLES-th RUN edge.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e                     state_q;
  logic                       core_rst_q;
  logic [RC_W-1:0]            rst_cnt_q;
  logic [N_CORES-1:0]         halted_mask_q;
  logic [N_CORES*CNT_W-1:0]   cyc_q;
  logic [CNT_W-1:0]           glob_q;
  logic                       done_q;
  logic                       timeout_q;

  // A halt arriving this cycle counts toward completion together with the
  // cores that are already halted or disabled.
  logic all_halt;
  assign all_halt = &(halted_mask_q | hlt_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      core_rst_q    <= 1'b1;
      rst_cnt_q     <= '0;
      halted_mask_q <= '0;
      cyc_q         <= '0;
      glob_q        <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q       <= ST_RESET;
            core_rst_q    <= 1'b1;
            rst_cnt_q     <= RC_LAST;
            halted_mask_q <= '0;
            cyc_q         <= '0;
            glob_q        <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        ST_RESET: begin
          if (rst_cnt_q == '0) begin
            state_q       <= ST_RUN;
            core_rst_q    <= 1'b0;
            // Disabled cores look already halted so they never block DONE.
            halted_mask_q <= ~core_en_i;
          end else begin
            rst_cnt_q <= rst_cnt_q - RC_ONE;
          end
        end
        ST_RUN: begin
          if (glob_q != '1) glob_q <= glob_q + CNT_ONE;
          // The hlt cycle itself is counted; afterwards the count freezes.
          for (int i = 0; i < N_CORES; i++) begin
            if (!halted_mask_q[i]) begin
              if (cyc_q[i*CNT_W +: CNT_W] != '1)
                cyc_q[i*CNT_W +: CNT_W] <= cyc_q[i*CNT_W +: CNT_W] + CNT_ONE;
              if (hlt_i[i]) halted_mask_q[i] <= 1'b1;
            end
          end
          // Halt takes priority over a watchdog expiring on the same edge.
          if (all_halt) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (glob_q == WD_LAST) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign core_rst_o        = core_rst_q;
  assign state_o           = state_q;
  assign halted_mask_o     = halted_mask_q;
  assign cycles_consumed_o = cyc_q;
  assign global_cycles_o   = glob_q;
  assign done_o            = done_q;
  assign timeout_o         = timeout_q;

endmodule
